// File: rtl/cgra_conf_loader.sv
// Configuration loader for the CGRA array: clears the array, then streams words column by column
// into the top-row north inputs with per-column conf_en. Optional checksum: CONF_LOADER_CHECKSUM_EN.
module cgra_conf_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 4,
  parameter int WORDS_PER_PE = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] conf_data_o,
  output logic [NUM_COLS-1:0]   conf_en_o,
  output logic                  clr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int WORDS_PER_COL = NUM_ROWS * WORDS_PER_PE;
  localparam int WCNT_W        = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
  localparam int COL_W         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_COL - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

`ifdef CONF_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CHECK, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_e;
`endif

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [COL_W-1:0]    col_q;
  logic [NUM_COLS-1:0] col_oh_q;
  logic                ready_q;
  logic                busy_q;
  logic                clr_q;
  logic                done_q;
  logic                accept;

  assign accept = in_valid_i & ready_q;

  // col_oh_q is non-zero only in LOAD, so it also gates the data passthrough.
  assign conf_en_o   = in_valid_i ? col_oh_q : '0;
  assign conf_data_o = (|col_oh_q) ? in_data_i : '0;
  assign in_ready_o  = ready_q;
  assign busy_o      = busy_q;
  assign clr_o       = clr_q;
  assign done_o      = done_q;

`ifdef CONF_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  err_q;

  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      acc_q <= '0;
    end else if (state_q == LOAD && accept) begin
      acc_q <= acc_q ^ in_data_i;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      col_q    <= '0;
      col_oh_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef CONF_LOADER_CHECKSUM_EN
      err_q    <= 1'b0;
`endif
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= CLEAR;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          state_q  <= LOAD;
          wcnt_q   <= '0;
          col_q    <= '0;
          col_oh_q <= NUM_COLS'(1);
          ready_q  <= 1'b1;
`ifdef CONF_LOADER_CHECKSUM_EN
          err_q    <= 1'b0;
`endif
        end
        LOAD: begin
          if (accept) begin
            // End-of-column and end-of-array are tested before incrementing, so nothing wraps.
            if (wcnt_q == WCNT_LAST) begin
              wcnt_q <= '0;
              if (col_q == COL_LAST) begin
                col_oh_q <= '0;
`ifdef CONF_LOADER_CHECKSUM_EN
                state_q  <= CHECK;
`else
                state_q  <= DONE;
                ready_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
`endif
              end else begin
                col_q    <= col_q + 1'b1;
                col_oh_q <= col_oh_q << 1;
              end
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
`ifdef CONF_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (in_data_i != acc_q) begin
              err_q <= 1'b1;
            end
            state_q <= DONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_conf_loader.sv
// Scoreboard bench for cgra_conf_loader on a 2x2 array with 5 words per PE (20 words per load).
module tb_cgra_conf_loader;

  localparam int DW      = 32;
  localparam int NR      = 2;
  localparam int NC      = 2;
  localparam int WPP     = 5;
  localparam int PER_COL = NR * WPP;
  localparam int TOTAL   = NC * PER_COL;
`ifdef CONF_LOADER_CHECKSUM_EN
  localparam int EXP_ACC  = TOTAL + 1;
  localparam int EXP_BUSY = TOTAL + 2;
`else
  localparam int EXP_ACC  = TOTAL;
  localparam int EXP_BUSY = TOTAL + 1;
`endif
  localparam logic [DW-1:0] GOOD_SUM = 32'h0000_0014;
  localparam logic [DW-1:0] BAD_SUM  = 32'h0000_0015;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] conf_data_o;
  logic [NC-1:0] conf_en_o;
  logic          clr_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  cgra_conf_loader #(
    .DATA_WIDTH  (DW),
    .NUM_ROWS    (NR),
    .NUM_COLS    (NC),
    .WORDS_PER_PE(WPP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .conf_data_o(conf_data_o),
    .conf_en_o  (conf_en_o),
    .clr_o      (clr_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_data_q[$];
  logic [NC-1:0] exp_en_q[$];
  logic [DW-1:0] obs_data_q[$];
  logic [NC-1:0] obs_en_q[$];

  int   n_clr, clr_cyc, n_busy, n_en_bad, n_acc, first_acc, last_acc, acc20_cyc, n_done, done_cyc;
  logic err_at_done, busy_at_done, timed_out;

  function automatic logic [DW-1:0] word_at(input int n, input logic [DW-1:0] trailer);
    return (n < TOTAL) ? DW'(n + 1) : trailer;
  endfunction

  // Expected stream: words 1..TOTAL, column index advancing every PER_COL words.
  task automatic push_expected();
    exp_data_q.delete();
    exp_en_q.delete();
    for (int i = 1; i <= TOTAL; i++) begin
      exp_data_q.push_back(DW'(i));
      exp_en_q.push_back(NC'(1) << ((i - 1) / PER_COL));
    end
  endtask

  // Drives one load and records what the DUT did; all judging is left to the calling test.
  task automatic run_load(input bit toggle, input int restart_at, input int rst_at,
                          input logic [DW-1:0] trailer);
    int  nw;
    bit  restarted;
    bit  stop;
    nw = 0; restarted = 0; stop = 0;
    n_clr = 0; clr_cyc = -1; n_busy = 0; n_en_bad = 0; n_acc = 0;
    first_acc = -1; last_acc = -1; acc20_cyc = -1; n_done = 0; done_cyc = -1;
    err_at_done = 1'b0; busy_at_done = 1'b0;
    obs_data_q.delete();
    obs_en_q.delete();
    @(posedge clk); #1;
    start_i    = 1'b1;
    in_valid_i = toggle ? 1'b0 : 1'b1;
    in_data_i  = word_at(0, trailer);
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (clr_o) begin n_clr++; if (clr_cyc < 0) clr_cyc = c; end
      if (busy_o) n_busy++;
      if (conf_en_o != '0) begin
        obs_data_q.push_back(conf_data_o);
        obs_en_q.push_back(conf_en_o);
        if (!in_valid_i || clr_o || !$onehot(conf_en_o)) n_en_bad++;
      end
      if (in_valid_i && in_ready_o) begin
        n_acc++;
        nw++;
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        if (n_acc == TOTAL) acc20_cyc = c;
      end
      if (done_o) begin
        n_done++; done_cyc = c; err_at_done = err_o; busy_at_done = busy_o;
        stop = 1;
      end
      if (rst_at >= 0 && n_acc == rst_at) stop = 1;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (stop) begin
        in_valid_i = 1'b0;
        if (rst_at >= 0 && n_acc == rst_at) rst_i = 1'b1;
        break;
      end
      if (restart_at >= 0 && n_acc == restart_at && !restarted) begin
        start_i = 1'b1;
        restarted = 1;
      end
      in_valid_i = toggle ? (((c + 1) % 2) == 1) : 1'b1;
      in_data_i  = word_at(nw, trailer);
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    timed_out  = !stop;
  endtask

  task automatic test_reset();
    int bad;
    rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hdead_beef; start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b, required 0", in_ready_o); end
    vectors++; if (conf_en_o !== '0) begin miscompares++; $display("FAIL rst_conf_en: got %b, required 0", conf_en_o); end
    vectors++; if (conf_data_o !== '0) begin miscompares++; $display("FAIL rst_conf_data: got %h, required 0", conf_data_o); end
    vectors++; if ({clr_o, busy_o, done_o, err_o} !== 4'b0) begin miscompares++; $display("FAIL rst_ctrl: got clr/busy/done/err %b, required 0000", {clr_o, busy_o, done_o, err_o}); end
    @(posedge clk); #1;
    rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_o !== 1'b0 || conf_en_o !== '0 || busy_o !== 1'b0 || clr_o !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_idle_valid: got %0d active cycles, required 0", bad); end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic test_full_load();
    logic [DW-1:0] od, ed;
    logic [NC-1:0] oe, ee;
    push_expected();
    run_load(1'b0, -1, -1, GOOD_SUM);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL full_timeout: got %b, required 0", timed_out); end
    vectors++; if (n_clr !== 1 || clr_cyc !== 1) begin miscompares++; $display("FAIL full_clr: got count %0d cycle %0d, required 1 at 1", n_clr, clr_cyc); end
    vectors++; if (first_acc !== clr_cyc + 1) begin miscompares++; $display("FAIL full_first_accept: got cycle %0d, required %0d", first_acc, clr_cyc + 1); end
    vectors++; if (acc20_cyc !== clr_cyc + TOTAL) begin miscompares++; $display("FAIL full_last_load: got cycle %0d, required %0d", acc20_cyc, clr_cyc + TOTAL); end
    vectors++; if (n_acc !== EXP_ACC) begin miscompares++; $display("FAIL full_accepts: got %0d, required %0d", n_acc, EXP_ACC); end
    vectors++; if (n_done !== 1 || done_cyc !== last_acc + 1) begin miscompares++; $display("FAIL full_done: got count %0d cycle %0d, required 1 at %0d", n_done, done_cyc, last_acc + 1); end
    vectors++; if (n_busy !== EXP_BUSY || busy_at_done !== 1'b0) begin miscompares++; $display("FAIL full_busy: got %0d cycles busy_at_done %b, required %0d and 0", n_busy, busy_at_done, EXP_BUSY); end
    vectors++; if (n_en_bad !== 0) begin miscompares++; $display("FAIL full_en_rule: got %0d bad cycles, required 0", n_en_bad); end
    vectors++; if (err_at_done !== 1'b0) begin miscompares++; $display("FAIL full_err: got %b, required 0", err_at_done); end
    while (obs_data_q.size() > 0) begin
      od = obs_data_q.pop_front(); oe = obs_en_q.pop_front();
      vectors++;
      if (exp_data_q.size() == 0) begin
        miscompares++; $display("FAIL full_extra_word: got %h en %b, required none", od, oe);
      end else begin
        ed = exp_data_q.pop_front(); ee = exp_en_q.pop_front();
        if (od !== ed || oe !== ee) begin miscompares++; $display("FAIL full_word: got %h en %b, required %h en %b", od, oe, ed, ee); end
      end
    end
    vectors++; if (exp_data_q.size() !== 0) begin miscompares++; $display("FAIL full_missing: got %0d words short, required 0", exp_data_q.size()); end
  endtask

  task automatic test_bubbles();
    logic [DW-1:0] od, ed;
    logic [NC-1:0] oe, ee;
    push_expected();
    run_load(1'b1, -1, -1, GOOD_SUM);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL bub_timeout: got %b, required 0", timed_out); end
    vectors++; if (n_en_bad !== 0) begin miscompares++; $display("FAIL bub_en_in_bubble: got %0d bad cycles, required 0", n_en_bad); end
    vectors++; if (n_acc !== EXP_ACC) begin miscompares++; $display("FAIL bub_accepts: got %0d, required %0d", n_acc, EXP_ACC); end
    vectors++; if (acc20_cyc !== clr_cyc + 2 * TOTAL) begin miscompares++; $display("FAIL bub_load_len: got cycle %0d, required %0d", acc20_cyc, clr_cyc + 2 * TOTAL); end
    vectors++; if (n_done !== 1 || done_cyc !== last_acc + 1) begin miscompares++; $display("FAIL bub_done: got count %0d cycle %0d, required 1 at %0d", n_done, done_cyc, last_acc + 1); end
    while (obs_data_q.size() > 0) begin
      od = obs_data_q.pop_front(); oe = obs_en_q.pop_front();
      vectors++;
      if (exp_data_q.size() == 0) begin
        miscompares++; $display("FAIL bub_extra_word: got %h en %b, required none", od, oe);
      end else begin
        ed = exp_data_q.pop_front(); ee = exp_en_q.pop_front();
        if (od !== ed || oe !== ee) begin miscompares++; $display("FAIL bub_word: got %h en %b, required %h en %b", od, oe, ed, ee); end
      end
    end
    vectors++; if (exp_data_q.size() !== 0) begin miscompares++; $display("FAIL bub_missing: got %0d words short, required 0", exp_data_q.size()); end
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] od, ed;
    logic [NC-1:0] oe, ee;
    push_expected();
    run_load(1'b0, 7, -1, GOOD_SUM);
    vectors++; if (n_clr !== 1) begin miscompares++; $display("FAIL restart_clr: got %0d pulses, required 1", n_clr); end
    vectors++; if (n_acc !== EXP_ACC) begin miscompares++; $display("FAIL restart_accepts: got %0d, required %0d", n_acc, EXP_ACC); end
    vectors++; if (n_done !== 1 || timed_out !== 1'b0) begin miscompares++; $display("FAIL restart_done: got %0d done timeout %b, required 1 and 0", n_done, timed_out); end
    while (obs_data_q.size() > 0) begin
      od = obs_data_q.pop_front(); oe = obs_en_q.pop_front();
      vectors++;
      if (exp_data_q.size() == 0) begin
        miscompares++; $display("FAIL restart_extra_word: got %h en %b, required none", od, oe);
      end else begin
        ed = exp_data_q.pop_front(); ee = exp_en_q.pop_front();
        if (od !== ed || oe !== ee) begin miscompares++; $display("FAIL restart_word: got %h en %b, required %h en %b", od, oe, ed, ee); end
      end
    end
    vectors++; if (exp_data_q.size() !== 0) begin miscompares++; $display("FAIL restart_missing: got %0d words short, required 0", exp_data_q.size()); end
    repeat (5) begin
      @(negedge clk);
      vectors++; if (clr_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL restart_after: got clr %b busy %b, required 0 0", clr_o, busy_o); end
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] od, ed;
    logic [NC-1:0] oe, ee;
    int late_done;
    push_expected();
    run_load(1'b0, -1, 12, GOOD_SUM);
    vectors++; if (n_done !== 0 || n_acc !== 12) begin miscompares++; $display("FAIL mrst_progress: got done %0d accepts %0d, required 0 and 12", n_done, n_acc); end
    @(posedge clk); #1;
    rst_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h1234_5678;
    @(negedge clk);
    vectors++; if ({in_ready_o, clr_o, busy_o, done_o, err_o} !== 5'b0 || conf_en_o !== '0 || conf_data_o !== '0) begin
      miscompares++; $display("FAIL mrst_outputs: got rdy/clr/busy/done/err %b en %b data %h, required all 0",
                              {in_ready_o, clr_o, busy_o, done_o, err_o}, conf_en_o, conf_data_o);
    end
    late_done = 0;
    repeat (5) begin @(negedge clk); if (done_o || in_ready_o) late_done++; end
    vectors++; if (late_done !== 0) begin miscompares++; $display("FAIL mrst_idle: got %0d active cycles, required 0", late_done); end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    while (obs_data_q.size() > 0) begin
      od = obs_data_q.pop_front(); oe = obs_en_q.pop_front();
      ed = exp_data_q.pop_front(); ee = exp_en_q.pop_front();
      vectors++; if (od !== ed || oe !== ee) begin miscompares++; $display("FAIL mrst_word: got %h en %b, required %h en %b", od, oe, ed, ee); end
    end
    vectors++; if (exp_data_q.size() !== TOTAL - 12) begin miscompares++; $display("FAIL mrst_remaining: got %0d, required %0d", exp_data_q.size(), TOTAL - 12); end
    push_expected();
    run_load(1'b0, -1, -1, GOOD_SUM);
    vectors++; if (n_clr !== 1 || n_acc !== EXP_ACC || n_done !== 1) begin
      miscompares++; $display("FAIL mrst_reload: got clr %0d accepts %0d done %0d, required 1 %0d 1", n_clr, n_acc, n_done, EXP_ACC);
    end
    while (obs_data_q.size() > 0) begin
      od = obs_data_q.pop_front(); oe = obs_en_q.pop_front();
      vectors++;
      if (exp_data_q.size() == 0) begin
        miscompares++; $display("FAIL mrst_reload_extra: got %h en %b, required none", od, oe);
      end else begin
        ed = exp_data_q.pop_front(); ee = exp_en_q.pop_front();
        if (od !== ed || oe !== ee) begin miscompares++; $display("FAIL mrst_reload_word: got %h en %b, required %h en %b", od, oe, ed, ee); end
      end
    end
    vectors++; if (exp_data_q.size() !== 0) begin miscompares++; $display("FAIL mrst_reload_missing: got %0d words short, required 0", exp_data_q.size()); end
  endtask

  task automatic test_checksum();
`ifdef CONF_LOADER_CHECKSUM_EN
    run_load(1'b0, -1, -1, GOOD_SUM);
    vectors++; if (err_at_done !== 1'b0 || n_done !== 1) begin miscompares++; $display("FAIL cks_good: got err %b done %0d, required 0 and 1", err_at_done, n_done); end
    run_load(1'b0, -1, -1, BAD_SUM);
    vectors++; if (err_at_done !== 1'b1 || n_done !== 1) begin miscompares++; $display("FAIL cks_bad: got err %b done %0d, required 1 and 1", err_at_done, n_done); end
    repeat (4) @(negedge clk);
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL cks_sticky: got %b, required 1", err_o); end
    run_load(1'b1, -1, -1, GOOD_SUM);
    vectors++; if (err_at_done !== 1'b0) begin miscompares++; $display("FAIL cks_cleared: got %b, required 0", err_at_done); end
`else
    run_load(1'b0, -1, -1, BAD_SUM);
    vectors++; if (err_at_done !== 1'b0 || n_acc !== TOTAL) begin miscompares++; $display("FAIL cks_off: got err %b accepts %0d, required 0 and %0d", err_at_done, n_acc, TOTAL); end
    @(negedge clk);
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL cks_off_idle: got %b, required 0", err_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_bubbles();
    test_start_ignored();
    test_mid_reset();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run by 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
